// File: rtl/mux_arb_pkg.sv
// Shared types, sizes and helpers for the round-robin mux arbiter.
// The tenure limit constants exist only when ARB_TIMEOUT_EN is defined.
package mux_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

`ifdef ARB_TIMEOUT_EN
    localparam int MAX_HOLD = 8;
    localparam int CNT_W    = 4;
`endif

    typedef enum logic {
        ARB_IDLE,
        ARB_OWN
    } arb_state_e;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first masked request after 'last',
// scanning last+1, last+2, ... modulo N_REQ.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last,
    input  logic [N_REQ-1:0] mask,
    output logic             valid,
    output logic [SEL_W-1:0] idx
);

    logic [N_REQ-1:0] eligible;
    logic [SEL_W-1:0] cand;

    assign eligible = req & mask;

    always_comb begin
        valid = 1'b0;
        idx   = last;
        cand  = last;
        // k = N_REQ wraps back to 'last' itself, so it is checked last
        for (int k = 1; k <= N_REQ; k++) begin
            cand = last + SEL_W'(k);
            if (!valid && eligible[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner arbiter for a shared 4:1 mux resource; owners hold until done or req drop.
// Optional preemptive tenure limit is built when ARB_TIMEOUT_EN is defined.
module mux_rr_arbiter
    import mux_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] sel,
    output logic             busy
);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] last_q, last_d;

    logic             pick_valid;
    logic [SEL_W-1:0] pick_idx;
    logic [SEL_W-1:0] pick_last;
    logic [N_REQ-1:0] pick_mask;
    logic             new_grant;
    logic             release_w;
    logic             timeout;

    // While owning, the picker looks for a successor excluding the current owner
    assign pick_last = (state_q == ARB_OWN) ? sel_q : last_q;
    assign pick_mask = (state_q == ARB_OWN) ? ~onehot(sel_q) : '1;

    rr_pick u_pick (
        .req   (req),
        .last  (pick_last),
        .mask  (pick_mask),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign timeout = (cnt_q >= CNT_W'(MAX_HOLD - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (new_grant) begin
            cnt_d = '0;
        end else if (state_q == ARB_OWN && cnt_q < CNT_W'(MAX_HOLD)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        last_d    = last_q;
        new_grant = 1'b0;
        release_w = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d   = ARB_OWN;
                    new_grant = 1'b1;
                end
            end
            ARB_OWN: begin
                // Timeout only forces a release when someone else is waiting
                release_w = done || !req[sel_q] || (timeout && pick_valid);
                if (release_w) begin
                    last_d = sel_q;
                    if (pick_valid) begin
                        new_grant = 1'b1;
                    end else begin
                        state_d = ARB_IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
        if (new_grant) begin
            grant_d = onehot(pick_idx);
            sel_d   = pick_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            last_q  <= SEL_W'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

    assign grant = grant_q;
    assign sel   = sel_q;
    assign busy  = |grant_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed-vector bench for mux_rr_arbiter: table of per-edge stimulus/expectations,
// plus hand sequences for tenure-limit behaviour (ARB_TIMEOUT_EN aware).
module tb_mux_rr_arbiter;
    import mux_arb_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;

    int n_cmp;
    int n_err;

    mux_rr_arbiter dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .done  (done),
        .grant (grant),
        .sel   (sel),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic [3:0] g;
        logic [1:0] s;
        logic       b;
    } vec_t;

    vec_t tv[23];

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one edge, then sample and check the structural invariants
    task automatic step();
        logic [3:0] g;
        @(posedge clk);
        #1;
        g = grant;
        n_cmp++;
        if ((g & (g - 4'd1)) != 4'd0) begin
            n_err++;
            $display("FAIL onehot0: grant %b at %0t", g, $time);
        end
        n_cmp++;
        if (busy !== (g != 4'd0) || (busy && !g[sel])) begin
            n_err++;
            $display("FAIL busy_sel: busy %b grant %b sel %0d at %0t", busy, g, sel, $time);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] eg, input logic [1:0] es, input logic eb);
        chk({tag, ".grant"}, grant, eg);
        chk({tag, ".sel"}, {2'b00, sel}, {2'b00, es});
        chk({tag, ".busy"}, {3'b000, busy}, {3'b000, eb});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        req   = 4'b0000;
        done  = 1'b0;

        //         rst   req     done  grant   sel   busy
        tv[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0}; // reset
        tv[1]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1}; // req0 first after reset
        tv[2]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1};
        tv[3]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1};
        tv[4]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1};
        tv[5]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1}; // wrap
        tv[6]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1}; // hold
        tv[7]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0}; // all drop -> idle
        tv[8]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1};
        tv[9]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1};
        tv[10] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0}; // sel keeps 2
        tv[11] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0}; // done ignored in idle
        tv[12] = '{1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1};
        tv[13] = '{1'b0, 4'b0011, 1'b1, 4'b0001, 2'd0, 1'b1}; // same-edge handover
        tv[14] = '{1'b0, 4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1};
        tv[15] = '{1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1}; // release by req drop
        tv[16] = '{1'b0, 4'b1010, 1'b1, 4'b1000, 2'd3, 1'b1};
        tv[17] = '{1'b1, 4'b1010, 1'b0, 4'b0000, 2'd0, 1'b0}; // reset mid-tenure, sel=3
        tv[18] = '{1'b0, 4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1}; // req0 wins after reset
        tv[19] = '{1'b0, 4'b1001, 1'b1, 4'b1000, 2'd3, 1'b1};
        tv[20] = '{1'b0, 4'b1001, 1'b1, 4'b0001, 2'd0, 1'b1};
        tv[21] = '{1'b0, 4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0}; // releaser excluded
        tv[22] = '{1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1};

        for (int i = 0; i < 23; i++) begin
            rst  = tv[i].rst;
            req  = tv[i].req;
            done = tv[i].done;
            step();
            check_out($sformatf("vec%0d", i), tv[i].g, tv[i].s, tv[i].b);
        end

        // Competing request arrives while owner 0 holds
        rst = 1'b1; req = 4'b0000; done = 1'b0;
        step();
        rst = 1'b0; req = 4'b0001;
        step();
        check_out("hold.start", 4'b0001, 2'd0, 1'b1);
        req = 4'b0101;
        for (int k = 1; k <= 12; k++) begin
            step();
`ifdef ARB_TIMEOUT_EN
            if (k < MAX_HOLD) check_out($sformatf("tmo.k%0d", k), 4'b0001, 2'd0, 1'b1);
            else              check_out($sformatf("tmo.k%0d", k), 4'b0100, 2'd2, 1'b1);
`else
            check_out($sformatf("hold.k%0d", k), 4'b0001, 2'd0, 1'b1);
`endif
        end
        done = 1'b1;
        step();
        done = 1'b0;
`ifdef ARB_TIMEOUT_EN
        check_out("tmo.done", 4'b0001, 2'd0, 1'b1);
`else
        check_out("hold.done", 4'b0100, 2'd2, 1'b1);
`endif

        // Lone owner is never preempted
        rst = 1'b1; req = 4'b0000;
        step();
        rst = 1'b0; req = 4'b0001;
        step();
        for (int k = 0; k < 20; k++) begin
            step();
            check_out($sformatf("lone.k%0d", k), 4'b0001, 2'd0, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
